// File: rtl/vsfx_pkg.sv
// Shared VSFX definitions: element-size encodings and per-size shift-amount widths.
// Imported by the shift datapath, its pipeline wrapper and the handshake interface.
package vsfx_pkg;

  typedef logic [1:0] esz_t;

  localparam esz_t ESZ_B   = 2'b00;
  localparam esz_t ESZ_H   = 2'b01;
  localparam esz_t ESZ_W   = 2'b10;
  localparam esz_t ESZ_RSV = 2'b11;

  localparam int SHAMT_B_W = 3;
  localparam int SHAMT_H_W = 4;
  localparam int SHAMT_W_W = 5;

endpackage

// File: rtl/vsfx_vsr_if.sv
// Operand/result handshake bundle for the vector shift-right unit.
// master drives operations and consumes results; slave is the unit itself.
interface vsfx_vsr_if
  import vsfx_pkg::*;
#(
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  esz_t             in_esz;
  logic             in_alg;
  logic [31:0]      in_vra;
  logic [31:0]      in_vrb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_vrt;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_esz, in_alg, in_vra, in_vrb, in_tag, out_ready,
    input  in_ready, out_valid, out_vrt, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_esz, in_alg, in_vra, in_vrb, in_tag, out_ready,
    output in_ready, out_valid, out_vrt, out_tag, out_err
  );

endinterface

// File: rtl/vsfx_vsr_core.sv
// Combinational element-wise right shift (logical or algebraic) for byte/half/word lanes.
// Only the low 3/4/5 bits of each shift-amount element are used; reserved size flags err.
module vsfx_vsr_core
  import vsfx_pkg::*;
(
  input  logic [31:0] vra,
  input  logic [31:0] vrb,
  input  esz_t        esz,
  input  logic        alg,
  output logic [31:0] vrt,
  output logic        err
);

  // Signed/unsigned results kept in separate variables so the arithmetic shift
  // is never evaluated in an unsigned context.
  logic signed [7:0]  b_s;
  logic        [7:0]  b_u;
  logic signed [15:0] h_s;
  logic        [15:0] h_u;
  logic signed [31:0] w_s;
  logic        [31:0] w_u;

  always_comb begin
    vrt = '0;
    err = 1'b0;
    b_s = '0;
    b_u = '0;
    h_s = '0;
    h_u = '0;
    w_s = '0;
    w_u = '0;
    case (esz)
      ESZ_B: begin
        for (int k = 0; k < 4; k++) begin
          b_s = $signed(vra[8*k +: 8]) >>> vrb[8*k +: SHAMT_B_W];
          b_u = vra[8*k +: 8] >> vrb[8*k +: SHAMT_B_W];
          vrt[8*k +: 8] = alg ? b_s : b_u;
        end
      end
      ESZ_H: begin
        for (int k = 0; k < 2; k++) begin
          h_s = $signed(vra[16*k +: 16]) >>> vrb[16*k +: SHAMT_H_W];
          h_u = vra[16*k +: 16] >> vrb[16*k +: SHAMT_H_W];
          vrt[16*k +: 16] = alg ? h_s : h_u;
        end
      end
      ESZ_W: begin
        w_s = $signed(vra) >>> vrb[SHAMT_W_W-1:0];
        w_u = vra >> vrb[SHAMT_W_W-1:0];
        vrt = alg ? w_s : w_u;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/vsfx_vsr.sv
// Two-stage pipelined vector shift-right: S1 holds operands, S2 holds the result.
// Latency 2 cycles, 1 op/cycle; stalls hold both stages, in_ready drops when S1 cannot drain.
module vsfx_vsr
  import vsfx_pkg::*;
#(
  parameter int TAG_W = 4
)(
  input  logic       clk,
  input  logic       rst_n,
  vsfx_vsr_if.slave  io
);

  logic             s1_vld_q, s1_vld_d;
  logic [31:0]      s1_vra_q, s1_vra_d;
  logic [31:0]      s1_vrb_q, s1_vrb_d;
  esz_t             s1_esz_q, s1_esz_d;
  logic             s1_alg_q, s1_alg_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_vld_q, s2_vld_d;
  logic [31:0]      s2_vrt_q, s2_vrt_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  logic        s2_adv;
  logic        in_rdy;
  logic        in_fire;
  logic [31:0] core_vrt;
  logic        core_err;

  vsfx_vsr_core u_core (
    .vra (s1_vra_q),
    .vrb (s1_vrb_q),
    .esz (s1_esz_q),
    .alg (s1_alg_q),
    .vrt (core_vrt),
    .err (core_err)
  );

  always_comb begin
    s2_adv  = s1_vld_q && (!s2_vld_q || io.out_ready);
    in_rdy  = !s1_vld_q || s2_adv;
    in_fire = io.in_valid && in_rdy;

    s1_vld_d = in_fire || (s1_vld_q && !s2_adv);
    s1_vra_d = in_fire ? io.in_vra : s1_vra_q;
    s1_vrb_d = in_fire ? io.in_vrb : s1_vrb_q;
    s1_esz_d = in_fire ? io.in_esz : s1_esz_q;
    s1_alg_d = in_fire ? io.in_alg : s1_alg_q;
    s1_tag_d = in_fire ? io.in_tag : s1_tag_q;

    s2_vld_d = s2_adv || (s2_vld_q && !io.out_ready);
    s2_vrt_d = s2_adv ? core_vrt : s2_vrt_q;
    s2_err_d = s2_adv ? core_err : s2_err_q;
    s2_tag_d = s2_adv ? s1_tag_q : s2_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_vra_q <= '0;
      s1_vrb_q <= '0;
      s1_esz_q <= ESZ_B;
      s1_alg_q <= 1'b0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_vrt_q <= '0;
      s2_tag_q <= '0;
      s2_err_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_vra_q <= s1_vra_d;
      s1_vrb_q <= s1_vrb_d;
      s1_esz_q <= s1_esz_d;
      s1_alg_q <= s1_alg_d;
      s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d;
      s2_vrt_q <= s2_vrt_d;
      s2_tag_q <= s2_tag_d;
      s2_err_q <= s2_err_d;
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.out_valid = s2_vld_q;
  assign io.out_vrt   = s2_vrt_q;
  assign io.out_tag   = s2_tag_q;
  assign io.out_err   = s2_err_q;

endmodule

// File: tb/tb_vsfx_vsr.sv
// Scoreboard bench for vsfx_vsr: directed, backpressure, random and reset scenarios
// checked against an arithmetic (floor-division) model of the shift.
module tb_vsfx_vsr;

  typedef struct {
    logic [31:0] vrt;
    logic [3:0]  tag;
    logic        err;
    bit          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   push_en = 1'b1;
  bit   rnd_done;
  exp_t sb[$];

  vsfx_vsr_if #(.TAG_W(4)) io ();

  vsfx_vsr #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Shift as division by 2**amt rounded toward minus infinity on the element's numeric value.
  function automatic void ref_vsr(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                                  input logic al, output logic [31:0] r, output logic e);
    longint w, abits, ev, amt, p, q, res, msk;
    r = '0;
    e = 1'b0;
    if (s == 2'd0) begin w = 8; abits = 3; end
    else if (s == 2'd1) begin w = 16; abits = 4; end
    else if (s == 2'd2) begin w = 32; abits = 5; end
    else begin e = 1'b1; return; end
    msk = (longint'(1) << w) - 1;
    res = 0;
    for (int k = 0; k < 32 / w; k++) begin
      ev = (longint'(a) >> (w * k)) & msk;
      if (al && ev >= (longint'(1) << (w - 1))) ev = ev - (longint'(1) << w);
      amt = (longint'(b) >> (w * k)) & ((longint'(1) << abits) - 1);
      p = longint'(1) << amt;
      if (ev >= 0) q = ev / p;
      else q = -((-ev + p - 1) / p);
      res = res | ((q & msk) << (w * k));
    end
    r = res[31:0];
  endfunction

  // Monitor: pop and compare on every output transfer; check stability while stalled.
  bit          hold_prev = 1'b0;
  logic [31:0] hv_vrt;
  logic [3:0]  hv_tag;
  logic        hv_err;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else if (io.out_valid) begin
      if (hold_prev) begin
        chk("hold_vrt", 64'(io.out_vrt), 64'(hv_vrt));
        chk("hold_tag", 64'(io.out_tag), 64'(hv_tag));
        chk("hold_err", 64'(io.out_err), 64'(hv_err));
      end
      if (io.out_ready) begin
        hold_prev = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got tag %0h with no pending operation", io.out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("out_vrt", 64'(io.out_vrt), 64'(mon_e.vrt));
          chk("out_tag", 64'(io.out_tag), 64'(mon_e.tag));
          chk("out_err", 64'(io.out_err), 64'(mon_e.err));
          if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'd2);
        end
      end else begin
        hold_prev = 1'b1;
        hv_vrt = io.out_vrt;
        hv_tag = io.out_tag;
        hv_err = io.out_err;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                      input logic al, input logic [3:0] t,
                      input logic [31:0] ev, input logic ee, input bit lat);
    int  w = 0;
    bit  acc = 1'b0;
    @(posedge clk);
    #1;
    io.in_valid = 1'b1;
    io.in_vra = a;
    io.in_vrb = b;
    io.in_esz = s;
    io.in_alg = al;
    io.in_tag = t;
    while (!acc) begin
      @(negedge clk);
      if (io.in_ready) begin
        acc = 1'b1;
      end else begin
        w++;
        if (w > 100) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: in_ready stayed 0 for tag %0h", t);
          break;
        end
        @(posedge clk);
        #1;
      end
    end
    if (acc && push_en) sb.push_back('{ev, t, ee, lat, cyc});
  endtask

  task automatic send_rand(input logic [3:0] t, input bit lat);
    logic [31:0] a, b, r;
    logic [1:0]  s;
    logic        al, e;
    a  = $urandom;
    b  = $urandom;
    s  = 2'($urandom_range(0, 3));
    al = 1'($urandom_range(0, 1));
    ref_vsr(a, b, s, al, r, e);
    send(a, b, s, al, t, r, e, lat);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results never appeared", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.in_vra = '0;
    io.in_vrb = '0;
    io.in_esz = '0;
    io.in_alg = 1'b0;
    io.in_tag = '0;
    io.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_out_vrt", 64'(io.out_vrt), 64'd0);
    chk("rst_out_tag", 64'(io.out_tag), 64'd0);
    chk("rst_out_err", 64'(io.out_err), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases with hand-derived results
    send(32'h80F01234, 32'h01040203, 2'b00, 1'b0, 4'h1, 32'h400F0406, 1'b0, 1'b1);
    idle();
    drain();
    send(32'h80F01234, 32'h01040203, 2'b00, 1'b1, 4'h2, 32'hC0FF0406, 1'b0, 1'b1);
    send(32'h80007FFF, 32'h000F0010, 2'b01, 1'b1, 4'h3, 32'hFFFF7FFF, 1'b0, 1'b1);
    send(32'hDEADBEEF, 32'h00000024, 2'b10, 1'b0, 4'h4, 32'h0DEADBEE, 1'b0, 1'b1);
    send(32'hFFFFFFFF, 32'h12345678, 2'b11, 1'b1, 4'h5, 32'h00000000, 1'b1, 1'b1);
    idle();
    drain();

    // Backpressure: four ops, consumer stalled for five cycles
    io.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          logic [31:0] a, b;
          a = $urandom;
          b = $urandom;
          ref_vsr(a, b, 2'b00, 1'b1, r, e);
          send(a, b, 2'b00, 1'b1, 4'(i), r, e, 1'b0);
        end
        idle();
      end
      begin
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready_c0", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        chk("bp_in_ready_c1", 64'(io.in_ready), 64'd1);
        for (int c = 2; c <= 4; c++) begin
          @(negedge clk);
          chk("bp_in_ready_full", 64'(io.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 io.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("bp_nogap_valid", 64'(io.out_valid), 64'd1);
        end
      end
    join
    drain();

    // Random traffic with random consumer stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand(4'($urandom), 1'b0);
          if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 io.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    io.out_ready = 1'b1;
    drain();

    // Reset with two operations in flight: both must vanish
    io.out_ready = 1'b0;
    push_en = 1'b0;
    send_rand(4'hE, 1'b0);
    send_rand(4'hF, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_flush_in_ready", 64'(io.in_ready), 64'd1);
    chk("rst_flush_out_vrt", 64'(io.out_vrt), 64'd0);
    chk("rst_flush_out_tag", 64'(io.out_tag), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_en = 1'b1;
    io.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_ghost_valid", 64'(io.out_valid), 64'd0);
    end
    send(32'h00000080, 32'h00000001, 2'b00, 1'b1, 4'h7, 32'h000000C0, 1'b0, 1'b1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vsfx_vsr.md
# vsfx_vsr

Pipelined vector shift-right unit for the VSFX (vector simple fixed-point) cluster: element-wise right shift of a 32-bit vector operand by per-element amounts, logical (vsrb/vsrh/vsrw) or algebraic (vsrab/vsrah/vsraw). It is the right-shift counterpart of the cluster's left-shift datapath. It adds a two-stage registered pipeline with valid/ready handshakes on both sides so it can sit between the VSFX issue queue and the result bus.

## Interface
Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_esz  in  2  element size: 00 byte, 01 halfword, 10 word, 11 reserved.
- in_alg  in  1  1 = algebraic (sign fill), 0 = logical (zero fill).
- in_vra  in  32  source vector.
- in_vrb  in  32  shift-amount vector.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_vrt  out  32  result vector.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  operation used reserved element size.

## Operation
- Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
- Element k of vra is shifted right by the low bits of element k of vrb:
  - byte: vrb[8k+2:8k]
  - halfword: vrb[16k+3:16k]
  - word: vrb[4:0]
- All higher vrb bits are ignored.
- Fill bits: logical shifts fill with 0. Algebraic shifts fill with the element MSB.
- Shift amount 0 returns the element unchanged. Elements never interact.
- Reserved esz=11: out_vrt = 0 and out_err = 1. Otherwise out_err = 0.
- Stage 1 (S1) registers the operands, esz, alg and tag. Stage 2 (S2) registers the computed result, err and tag. out_* are driven directly from the S2 registers.
- Advance rules:
  - s2_adv = S1 valid && (!S2 valid || out_ready).
  - in_ready = !S1 valid || s2_adv. in_ready is combinational, with no dependence on in_valid.
- A stage's data registers load only when that stage advances; otherwise they hold. A valid bit clears when its content leaves and nothing replaces it.

## Timing
- Latency: an operation accepted in cycle N has out_valid = 1 in cycle N+2, provided out_ready was not holding S2 full.
- Throughput: 1 operation per cycle with out_ready held at 1.
- Backpressure: with out_ready = 0, at most 2 operations are held (S1 + S2), after which in_ready = 0.
  - out_vrt, out_tag and out_err stay stable while out_valid && !out_ready.
  - Ordering is strict FIFO. No operation is dropped or duplicated.
- Simultaneous events: accept and emit in the same cycle are allowed. With S1 and S2 full and out_ready = 1, in_ready = 1 and all three move in one cycle.
- Reset:
  - Asserting rst_n low clears both valid bits immediately. Operations in flight are discarded, not completed.
  - Reset values: out_valid 0, out_vrt 0, out_tag 0, out_err 0.
  - in_ready reads 1 while the pipeline is empty, including during reset.

## Structure
- Shared package vsfx_pkg holds:
  - ESZ_B = 2'b00, ESZ_H = 2'b01, ESZ_W = 2'b10, ESZ_RSV = 2'b11.
  - A typedef for the 2-bit esz field.
  - Localparams for the per-size shift-amount widths (3/4/5).
- One combinational sub-module, vsfx_vsr_core (inputs vra, vrb, esz, alg; outputs vrt, err), placed between S1 and S2. It is reusable by a future non-pipelined variant.
- The handshake and valid/data registers live in vsfx_vsr.

## Test plan
- Byte, logical: vra = 0x80F01234, vrb = 0x01040203, esz = 00, alg = 0 -> out_vrt = 0x400F0406, out_err = 0, out_valid 2 cycles after accept.
- Byte, algebraic: same operands with alg = 1 -> out_vrt = 0xC0FF0406.
- Halfword, algebraic, upper-bit masking: vra = 0x80007FFF, vrb = 0x000F0010, esz = 01, alg = 1 -> out_vrt = 0xFFFF7FFF. The shift amounts used are 15 and 0.
- Word, logical, masking: vra = 0xDEADBEEF, vrb = 0x00000024, esz = 10, alg = 0 -> out_vrt = 0x0DEADBEE.
- Backpressure and order:
  - Stimulus: 4 back-to-back operations (tags 1..4) with out_ready = 0 for 5 cycles, then 1.
  - Response: in_ready drops after tags 1 and 2 are accepted, outputs hold stable, results emerge in order 1, 2, 3, 4 with no gaps once released.
- Reserved size and reset:
  - esz = 11 -> out_vrt = 0, out_err = 1.
  - rst_n pulsed low while 2 operations are in flight -> out_valid = 0 immediately, and none of those tags ever appears on the output.
